// File: rtl/rgb_to_binary_image_if.sv
// Pixel stream bundle for rgb_to_binary_image: an RGB input stream and a binary output stream.
// The block takes the slave side; the source/sink environment takes the master side.
interface rgb_to_binary_image_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_r;
    logic [7:0] in_g;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pixel;
    logic       out_sof;
    logic       out_eol;

    modport slave (
        input  in_valid, in_r, in_g, in_b, out_ready,
        output in_ready, out_valid, out_pixel, out_sof, out_eol
    );

    modport master (
        output in_valid, in_r, in_g, in_b, out_ready,
        input  in_ready, out_valid, out_pixel, out_sof, out_eol
    );
endinterface

// File: rtl/rgb_to_binary_image.sv
// Thresholds the luma of an RGB raster into a 1-bit frame buffer, then replays the
// whole frame as a 0x00/0xFF pixel stream with start-of-frame and end-of-line flags.
module rgb_to_binary_image #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             threshold,
    rgb_to_binary_image_if.slave   bus,
    output logic                   frame_done
);

    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [0:0] ST_LOAD  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]       state_q,       state_d;
    logic [COL_W-1:0] wr_col_q,      wr_col_d;
    logic [ROW_W-1:0] wr_row_q,      wr_row_d;
    logic [COL_W-1:0] rd_col_q,      rd_col_d;
    logic [ROW_W-1:0] rd_row_q,      rd_row_d;
    logic [7:0]       thr_q,         thr_d;
    logic             fetched_all_q, fetched_all_d;
    logic             out_valid_q,   out_valid_d;
    logic             out_sof_q,     out_sof_d;
    logic             out_eol_q,     out_eol_d;
    logic             frame_done_q,  frame_done_d;
    logic             rd_bit_q;

    logic             frame_mem [NPIX];

    logic [15:0]       luma_full;
    logic [7:0]        luma;
    logic [7:0]        thr_eff;
    logic              first_px;
    logic              pix_bit;
    logic              in_fire;
    logic              out_fire;
    logic              fetch_en;
    logic              wr_last_col;
    logic              wr_last_row;
    logic              rd_last_col;
    logic              rd_last_row;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    // Worst case 256*255 = 65280, so 16 bits never overflow.
    assign luma_full = 16'd77  * {8'd0, bus.in_r}
                     + 16'd150 * {8'd0, bus.in_g}
                     + 16'd29  * {8'd0, bus.in_b};
    assign luma      = 8'(luma_full >> 8);

    // The first pixel of a frame is judged against the live port value, since thr_q
    // only captures it on that same edge.
    assign first_px  = (wr_row_q == '0) && (wr_col_q == '0);
    assign thr_eff   = first_px ? threshold : thr_q;
    assign pix_bit   = (luma >= thr_eff);

    assign wr_last_col = (wr_col_q == COL_W'(IMG_W - 1));
    assign wr_last_row = (wr_row_q == ROW_W'(IMG_H - 1));
    assign rd_last_col = (rd_col_q == COL_W'(IMG_W - 1));
    assign rd_last_row = (rd_row_q == ROW_W'(IMG_H - 1));

    assign wr_addr = ADDR_W'(wr_row_q) * ADDR_W'(IMG_W) + ADDR_W'(wr_col_q);
    assign rd_addr = ADDR_W'(rd_row_q) * ADDR_W'(IMG_W) + ADDR_W'(rd_col_q);

    assign in_fire  = (state_q == ST_LOAD) && bus.in_valid;
    assign out_fire = out_valid_q && bus.out_ready;

    // Refill the output register whenever it is empty or being emptied this cycle;
    // this gives back-to-back transfers and freezes the output during a stall.
    assign fetch_en = (state_q == ST_DRAIN) && !fetched_all_q
                    && (!out_valid_q || bus.out_ready);

    always_comb begin
        state_d       = state_q;
        wr_col_d      = wr_col_q;
        wr_row_d      = wr_row_q;
        rd_col_d      = rd_col_q;
        rd_row_d      = rd_row_q;
        thr_d         = thr_q;
        fetched_all_d = fetched_all_q;
        out_valid_d   = out_valid_q;
        out_sof_d     = out_sof_q;
        out_eol_d     = out_eol_q;
        frame_done_d  = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (in_fire) begin
                    if (first_px) begin
                        thr_d = threshold;
                    end
                    if (wr_last_col) begin
                        wr_col_d = '0;
                        if (wr_last_row) begin
                            wr_row_d = '0;
                            state_d  = ST_DRAIN;
                        end else begin
                            wr_row_d = wr_row_q + 1'b1;
                        end
                    end else begin
                        wr_col_d = wr_col_q + 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                if (fetch_en) begin
                    out_valid_d = 1'b1;
                    out_sof_d   = (rd_row_q == '0) && (rd_col_q == '0);
                    out_eol_d   = rd_last_col;
                    if (rd_last_col) begin
                        rd_col_d = '0;
                        if (rd_last_row) begin
                            rd_row_d      = '0;
                            fetched_all_d = 1'b1;
                        end else begin
                            rd_row_d = rd_row_q + 1'b1;
                        end
                    end else begin
                        rd_col_d = rd_col_q + 1'b1;
                    end
                end else if (out_fire) begin
                    // Only reachable once every pixel has been fetched: this is the last one.
                    out_valid_d   = 1'b0;
                    out_sof_d     = 1'b0;
                    out_eol_d     = 1'b0;
                    fetched_all_d = 1'b0;
                    frame_done_d  = 1'b1;
                    state_d       = ST_LOAD;
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_LOAD;
            wr_col_q      <= '0;
            wr_row_q      <= '0;
            rd_col_q      <= '0;
            rd_row_q      <= '0;
            thr_q         <= '0;
            fetched_all_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_sof_q     <= 1'b0;
            out_eol_q     <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_col_q      <= wr_col_d;
            wr_row_q      <= wr_row_d;
            rd_col_q      <= rd_col_d;
            rd_row_q      <= rd_row_d;
            thr_q         <= thr_d;
            fetched_all_q <= fetched_all_d;
            out_valid_q   <= out_valid_d;
            out_sof_q     <= out_sof_d;
            out_eol_q     <= out_eol_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // Frame buffer: plain write port plus registered read, left uncleared by reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            frame_mem[wr_addr] <= pix_bit;
        end
        if (fetch_en) begin
            rd_bit_q <= frame_mem[rd_addr];
        end
    end

    // Gating with out_valid_q keeps the pixel at 0x00 while idle or in reset.
    assign bus.out_pixel = {8{out_valid_q & rd_bit_q}};
    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.in_ready  = (state_q == ST_LOAD);
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_rgb_to_binary_image.sv
// Randomised bench for rgb_to_binary_image on a 4x3 frame, checked against a luma/threshold
// model evaluated directly from the per-frame pixel arrays.
module tb_rgb_to_binary_image;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] threshold;
    logic       frame_done;

    rgb_to_binary_image_if bus();

    rgb_to_binary_image #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .threshold  (threshold),
        .bus        (bus),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] fr_r   [N];
    logic [7:0] fr_g   [N];
    logic [7:0] fr_b   [N];
    logic [7:0] fr_thr [N];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int luma_of(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return (77 * int'(r) + 150 * int'(g) + 29 * int'(b)) / 256;
    endfunction

    // The whole frame is judged against the threshold presented with pixel 0.
    function automatic logic [7:0] exp_pixel(input int k);
        return (luma_of(fr_r[k], fr_g[k], fr_b[k]) >= int'(fr_thr[0])) ? 8'hFF : 8'h00;
    endfunction

    task automatic fill_uniform(input logic [7:0] v, input logic [7:0] thr);
        for (int k = 0; k < N; k++) begin
            fr_r[k] = v; fr_g[k] = v; fr_b[k] = v; fr_thr[k] = thr;
        end
    endtask

    task automatic fill_checker(input logic [7:0] thr);
        for (int k = 0; k < N; k++) begin
            bit ok = 1'b0;
            fr_thr[k] = thr;
            for (int t = 0; t < 1000 && !ok; t++) begin
                fr_r[k] = 8'($urandom); fr_g[k] = 8'($urandom); fr_b[k] = 8'($urandom);
                ok = ((luma_of(fr_r[k], fr_g[k], fr_b[k]) >= int'(thr)) == (k % 2 == 0));
            end
            if (!ok) begin
                fr_r[k] = (k % 2 == 0) ? 8'hFF : 8'h00;
                fr_g[k] = fr_r[k]; fr_b[k] = fr_r[k];
            end
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) begin
            fr_r[k] = 8'($urandom); fr_g[k] = 8'($urandom); fr_b[k] = 8'($urandom);
            fr_thr[k] = 8'($urandom);
        end
    endtask

    task automatic do_reset(input int cycles);
        #1;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_in_ready",   32'(bus.in_ready),  32'd1);
        check_val("rst_out_valid",  32'(bus.out_valid), 32'd0);
        check_val("rst_out_pixel",  32'(bus.out_pixel), 32'd0);
        check_val("rst_frame_done", 32'(frame_done),    32'd0);
        check_val("rst_out_eol",    32'(bus.out_eol),   32'd0);
        $display("reset: %0d cycles, in_ready=%0d out_valid=%0d", cycles, bus.in_ready, bus.out_valid);
        @(posedge clk);
    endtask

    // Returns right after the edge that accepts the last pixel.
    task automatic send_frame(input bit gaps);
        for (int k = 0; k < N; k++) begin
            bit done = 1'b0;
            int budget = 0;
            while (!done) begin
                bit fire;
                #1;
                bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.in_r = fr_r[k]; bus.in_g = fr_g[k]; bus.in_b = fr_b[k];
                threshold = fr_thr[k];
                bus.out_ready = 1'($urandom_range(0, 1));
                check_val("load_out_valid", 32'(bus.out_valid), 32'd0);
                fire = bus.in_valid && bus.in_ready;
                @(posedge clk);
                if (fire) begin
                    done = 1'b1;
                    $display("in  k=%0d rgb=(%0d,%0d,%0d) thr=%0d", k, fr_r[k], fr_g[k], fr_b[k], fr_thr[k]);
                end
                budget++;
                if (!done && budget > 64) begin
                    check_val("send_timeout", 32'(k), 32'(N));
                    return;
                end
            end
        end
    endtask

    task automatic drain_frame(input bit rand_ready, input int stop_after);
        int         c = 0;
        int         xf = 0;
        bit         stalled = 1'b0;
        bit         seen = 1'b0;
        logic [7:0] hp = 8'h00;
        logic       hs = 1'b0;
        logic       he = 1'b0;
        while (xf < stop_after && c < 200) begin
            #1;
            c++;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_r = 8'($urandom); bus.in_g = 8'($urandom); bus.in_b = 8'($urandom);
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            check_val("drain_in_ready",   32'(bus.in_ready), 32'd0);
            check_val("drain_frame_done", 32'(frame_done),   32'd0);
            if (!seen && bus.out_valid) begin
                seen = 1'b1;
                check_val("first_out_latency", 32'(c), 32'd2);
            end
            if (stalled) begin
                check_val("stall_valid", 32'(bus.out_valid), 32'd1);
                check_val("stall_pixel", 32'(bus.out_pixel), 32'(hp));
                check_val("stall_sof",   32'(bus.out_sof),   32'(hs));
                check_val("stall_eol",   32'(bus.out_eol),   32'(he));
            end
            if (bus.out_valid && bus.out_ready) begin
                check_val("out_pixel", 32'(bus.out_pixel), 32'(exp_pixel(xf)));
                check_val("out_sof",   32'(bus.out_sof),   32'(xf == 0));
                check_val("out_eol",   32'(bus.out_eol),   32'((xf % W) == W - 1));
                $display("out k=%0d pixel=%02h sof=%0d eol=%0d", xf, bus.out_pixel, bus.out_sof, bus.out_eol);
                xf++;
                stalled = 1'b0;
            end else if (bus.out_valid) begin
                stalled = 1'b1;
                hp = bus.out_pixel; hs = bus.out_sof; he = bus.out_eol;
            end
            @(posedge clk);
        end
        if (xf < stop_after) begin
            check_val("drain_timeout", 32'(xf), 32'(stop_after));
        end
        if (stop_after == N) begin
            #1;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            check_val("done_pulse",     32'(frame_done),    32'd1);
            check_val("done_out_valid", 32'(bus.out_valid), 32'd0);
            check_val("done_in_ready",  32'(bus.in_ready),  32'd1);
            @(posedge clk);
            #1;
            check_val("done_single", 32'(frame_done), 32'd0);
            $display("frame_done seen, drain took %0d cycles", c);
            @(posedge clk);
        end
    endtask

    initial begin
        rst           = 1'b1;
        threshold     = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_r      = 8'd0;
        bus.in_g      = 8'd0;
        bus.in_b      = 8'd0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        do_reset(2);

        // Luma exactly 100: the comparison is inclusive.
        fill_uniform(8'd100, 8'd100);
        send_frame(1'b0);
        drain_frame(1'b0, N);
        fill_uniform(8'd100, 8'd101);
        send_frame(1'b0);
        drain_frame(1'b0, N);

        // Alternating white/black frame, first at full rate then with gaps and stalls.
        fill_checker(8'd128);
        send_frame(1'b0);
        drain_frame(1'b0, N);
        send_frame(1'b1);
        drain_frame(1'b1, N);

        // Threshold changes mid-frame must not matter after pixel 0.
        fill_uniform(8'd150, 8'd200);
        for (int k = 5; k < N; k++) fr_thr[k] = 8'd0;
        send_frame(1'b0);
        drain_frame(1'b0, N);

        for (int f = 0; f < 4; f++) begin
            fill_random();
            send_frame(1'b1);
            drain_frame(1'b1, N);
        end

        // Abandon a frame part-way through draining, then run a fresh one.
        fill_random();
        send_frame(1'b0);
        drain_frame(1'b0, 5);
        do_reset(1);
        fill_random();
        send_frame(1'b1);
        drain_frame(1'b1, N);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
